// File: rtl/regfile_commit_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared types and default widths for the register-file commit sequencer.
//   DEF_D_WIDTH / DEF_A_WIDTH : default MSB indices of data and register address
//   DEF_DEPTH                 : default number of pending-write entries
//   reg_addr_t / reg_data_t   : register address and data words
//   commit_entry_t            : one pending register write {addr, data}
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int DEF_D_WIDTH = 31;
    localparam int DEF_A_WIDTH = 4;
    localparam int DEF_DEPTH   = 4;

    typedef logic [DEF_A_WIDTH:0] reg_addr_t;
    typedef logic [DEF_D_WIDTH:0] reg_data_t;

    typedef struct packed {
        reg_addr_t addr;
        reg_data_t data;
    } commit_entry_t;

endpackage

// File: rtl/regfile_commit_sequencer_if.sv
// ---------------------------------------------------------------------------
// regfile_commit_sequencer_if
// Bundles every signal between the commit sequencer and its neighbours:
//   commit side  : commitValid0/1, commitAddr0/1, commitData0/1, commitReady
//   write side   : regWrite, validCommit, wraddress, wdata
//   read forward : address1/2 in, fwdHit1/2 and fwdData1/2 out
//   status       : count (occupied entries)
// master = ROB / pipeline side, slave = the sequencer itself.
// ---------------------------------------------------------------------------
interface regfile_commit_sequencer_if
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int DEPTH   = DEF_DEPTH
) ();

    logic                     commitValid0;
    logic [A_WIDTH:0]         commitAddr0;
    logic [D_WIDTH:0]         commitData0;
    logic                     commitValid1;
    logic [A_WIDTH:0]         commitAddr1;
    logic [D_WIDTH:0]         commitData1;
    logic                     commitReady;

    logic                     regWrite;
    logic                     validCommit;
    logic [A_WIDTH:0]         wraddress;
    logic [D_WIDTH:0]         wdata;

    logic [A_WIDTH:0]         address1;
    logic [A_WIDTH:0]         address2;
    logic                     fwdHit1;
    logic [D_WIDTH:0]         fwdData1;
    logic                     fwdHit2;
    logic [D_WIDTH:0]         fwdData2;

    logic [$clog2(DEPTH):0]   count;

    modport master (
        output commitValid0, commitAddr0, commitData0,
        output commitValid1, commitAddr1, commitData1,
        output address1, address2,
        input  commitReady, regWrite, validCommit, wraddress, wdata,
        input  fwdHit1, fwdData1, fwdHit2, fwdData2, count
    );

    modport slave (
        input  commitValid0, commitAddr0, commitData0,
        input  commitValid1, commitAddr1, commitData1,
        input  address1, address2,
        output commitReady, regWrite, validCommit, wraddress, wdata,
        output fwdHit1, fwdData1, fwdHit2, fwdData2, count
    );

endinterface

// File: rtl/regfile_commit_sequencer_lookup.sv
// ---------------------------------------------------------------------------
// pending_write_lookup
// Combinational search of the pending-write ring for one read address.
//   entry_addr/entry_data : ring storage (DEPTH entries)
//   head, count           : oldest occupied slot and number of occupied slots
//   rd_addr               : register being read
//   hit, data             : youngest pending write to rd_addr (data=0 on miss)
// Register 0 is hard-wired and never hits.
// ---------------------------------------------------------------------------
module pending_write_lookup
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic [A_WIDTH:0]          entry_addr [DEPTH],
    input  logic [D_WIDTH:0]          entry_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  head,
    input  logic [$clog2(DEPTH):0]    count,
    input  logic [A_WIDTH:0]          rd_addr,
    output logic                      hit,
    output logic [D_WIDTH:0]          data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk from oldest (head) to youngest; a later match overwrites an
    // earlier one, so the result is the entry nearest the tail. Indexing is
    // relative to head, which keeps the ordering correct across the wrap.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (rd_addr != '0) && (entry_addr[idx] == rd_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_commit_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_commit_sequencer
// Buffers up to two in-order ROB commits per cycle in a small ring and
// retires one entry per cycle to the register file's single write port,
// forwarding not-yet-retired writes to two read ports.
//   clk, resetN : clock and synchronous active-low reset
//   bus (slave) : commit inputs / commitReady, write port outputs,
//                 read-forwarding addresses and results, occupancy count
// ---------------------------------------------------------------------------
module regfile_commit_sequencer
    import regfile_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        resetN,
    regfile_commit_sequencer_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    logic [A_WIDTH:0] entry_addr [DEPTH];
    logic [D_WIDTH:0] entry_data [DEPTH];

    logic             commit_ready;
    logic             accept0;
    logic             accept1;
    logic             push0;
    logic             push1;
    logic             pop;
    logic [CW-1:0]    num_push;
    logic [PW-1:0]    slot1_idx;

    // Readiness depends only on registered occupancy, so the ROB never sees
    // a combinational loop through its own commit valids.
    assign commit_ready = (count_q <= CW'(DEPTH - 2));

    // Writes to x0 are dropped at the door; they never occupy a slot.
    assign accept0  = bus.commitValid0 && (bus.commitAddr0 != '0);
    assign accept1  = bus.commitValid1 && (bus.commitAddr1 != '0);
    assign push0    = commit_ready && accept0;
    assign push1    = commit_ready && accept1;
    assign num_push = CW'(push0) + CW'(push1);

    // Slot 1 packs directly behind slot 0, or takes tail itself if slot 0
    // was not stored.
    assign slot1_idx = push0 ? (tail + PW'(1)) : tail;

    // The register file always accepts, so an occupied head retires every cycle.
    assign pop = (count_q != '0);

    // ---- state update: pointers and occupancy ----
    always_ff @(posedge clk) begin
        if (!resetN) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail    <= tail + num_push[PW-1:0];
            count_q <= count_q + num_push - CW'(pop);
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push0) begin
            entry_addr[tail] <= bus.commitAddr0;
            entry_data[tail] <= bus.commitData0;
        end
        if (push1) begin
            entry_addr[slot1_idx] <= bus.commitAddr1;
            entry_data[slot1_idx] <= bus.commitData1;
        end
    end

    // ---- write port: head entry, zeroed while empty ----
    assign bus.regWrite    = pop;
    assign bus.validCommit = pop;
    assign bus.wraddress   = pop ? entry_addr[head] : '0;
    assign bus.wdata       = pop ? entry_data[head] : '0;
    assign bus.commitReady = commit_ready;
    assign bus.count       = count_q;

    // ---- read forwarding ----
    pending_write_lookup #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_lookup1 (
        .entry_addr (entry_addr),
        .entry_data (entry_data),
        .head       (head),
        .count      (count_q),
        .rd_addr    (bus.address1),
        .hit        (bus.fwdHit1),
        .data       (bus.fwdData1)
    );

    pending_write_lookup #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) u_lookup2 (
        .entry_addr (entry_addr),
        .entry_data (entry_data),
        .head       (head),
        .count      (count_q),
        .rd_addr    (bus.address2),
        .hit        (bus.fwdHit2),
        .data       (bus.fwdData2)
    );

endmodule

// File: tb/tb_regfile_commit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_commit_sequencer
// Directed stimulus for the commit sequencer. Each accepted commit pushes
// its hand-written {addr, data} into an expected-write queue; a monitor on
// the falling edge pops and compares whenever regWrite is presented.
// ---------------------------------------------------------------------------
module tb_regfile_commit_sequencer;
    import regfile_pkg::*;

    localparam int D_WIDTH = 31;
    localparam int A_WIDTH = 4;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;

    always #5 clk = ~clk;

    regfile_commit_sequencer_if #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) bus ();

    regfile_commit_sequencer #(
        .D_WIDTH (D_WIDTH),
        .A_WIDTH (A_WIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    commit_entry_t exp_q [$];
    commit_entry_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        bus.commitValid0 = 1'b0;
        bus.commitAddr0  = '0;
        bus.commitData0  = '0;
        bus.commitValid1 = 1'b0;
        bus.commitAddr1  = '0;
        bus.commitData1  = '0;
    endtask

    // Waits (bounded) for commitReady, then presents both slots and records
    // the writes that must eventually appear, in commit order.
    task automatic drive(input int v0, input int a0, input int d0,
                         input int v1, input int a1, input int d1);
        int guard;
        guard = 0;
        while (!bus.commitReady && guard < 20) begin
            step();
            guard++;
        end
        if (!bus.commitReady) begin
            n_cmp++;
            n_err++;
            $display("FAIL ready_timeout: commitReady stayed 0 for %0d cycles", guard);
        end else begin
            bus.commitValid0 = (v0 != 0);
            bus.commitAddr0  = (A_WIDTH+1)'(a0);
            bus.commitData0  = (D_WIDTH+1)'(d0);
            bus.commitValid1 = (v1 != 0);
            bus.commitAddr1  = (A_WIDTH+1)'(a1);
            bus.commitData1  = (D_WIDTH+1)'(d1);
            if (v0 != 0 && a0 != 0)
                exp_q.push_back(commit_entry_t'{addr: reg_addr_t'(a0), data: reg_data_t'(d0)});
            if (v1 != 0 && a1 != 0)
                exp_q.push_back(commit_entry_t'{addr: reg_addr_t'(a1), data: reg_data_t'(d1)});
        end
    endtask

    task automatic commit(input int v0, input int a0, input int d0,
                          input int v1, input int a1, input int d1);
        drive(v0, a0, d0, v1, a1, d1);
        step();
        clear_commit();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (bus.count != '0 && g < 40) begin
            step();
            g++;
        end
        chk("drain_count", bus.count, 0);
    endtask

    // Scoreboard monitor: one retirement per cycle with regWrite high.
    always @(negedge clk) begin
        if (resetN && bus.regWrite) begin
            chk("validCommit", bus.validCommit, 1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data %0d with nothing pending",
                         bus.wraddress, bus.wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", bus.wraddress, mon_e.addr);
                chk("wr_data", bus.wdata, mon_e.data);
            end
        end
    end

    // The ROB side must never commit while the sequencer is not ready.
    always @(posedge clk) begin
        if (resetN) begin
            assert (!((bus.commitValid0 || bus.commitValid1) && !bus.commitReady))
            else begin
                n_err++;
                $display("FAIL protocol: commit offered while commitReady=0");
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_commit();
        bus.address1 = '0;
        bus.address2 = '0;
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
        bus.address1 = 5'd5;
        bus.address2 = 5'd5;
        step();

        // Reset / idle
        chk("rst_count",       bus.count, 0);
        chk("rst_regWrite",    bus.regWrite, 0);
        chk("rst_validCommit", bus.validCommit, 0);
        chk("rst_ready",       bus.commitReady, 1);
        chk("rst_fwdHit1",     bus.fwdHit1, 0);
        chk("rst_fwdHit2",     bus.fwdHit2, 0);

        // Single commit, one-cycle latency to the write port
        commit(1, 4, 60, 0, 0, 0);
        chk("single_regWrite",  bus.regWrite, 1);
        chk("single_wraddress", bus.wraddress, 4);
        chk("single_wdata",     bus.wdata, 60);
        chk("single_count",     bus.count, 1);
        step();
        chk("single_count_after",    bus.count, 0);
        chk("single_regWrite_after", bus.regWrite, 0);

        // Dual commit to the same register: youngest forwards, oldest writes first
        bus.address1 = 5'd3;
        drive(1, 3, 60, 1, 3, 9);
        chk("dual_not_visible_yet", bus.fwdHit1, 0);
        step();
        clear_commit();
        chk("dual_count",    bus.count, 2);
        chk("dual_fwdHit1",  bus.fwdHit1, 1);
        chk("dual_fwdData1", bus.fwdData1, 9);
        chk("dual_wdata0",   bus.wdata, 60);
        step();
        chk("dual_fwdData1_b", bus.fwdData1, 9);
        chk("dual_wdata1",     bus.wdata, 9);
        step();
        chk("dual_fwdHit1_after", bus.fwdHit1, 0);

        // Back-to-back dual commits: backpressure at count 3
        commit(1, 10, 100, 1, 11, 110);
        chk("bp_ready_at2", bus.commitReady, 1);
        commit(1, 12, 120, 1, 13, 130);
        chk("bp_count3", bus.count, 3);
        chk("bp_ready0", bus.commitReady, 0);
        commit(1, 14, 140, 1, 15, 150);
        chk("bp_count3_again", bus.count, 3);
        drain();

        // x0 in slot 0 is dropped; address 0 never forwards
        bus.address1 = 5'd9;
        bus.address2 = 5'd0;
        commit(1, 0, 55, 1, 9, 80);
        chk("x0_count",     bus.count, 1);
        chk("x0_wraddress", bus.wraddress, 9);
        chk("x0_fwdHit2",   bus.fwdHit2, 0);
        chk("x0_fwdHit1",   bus.fwdHit1, 1);
        chk("x0_fwdData1",  bus.fwdData1, 80);
        step();
        chk("x0_count_after", bus.count, 0);

        // Pointers now sit at 2: the next commits straddle the wrap
        bus.address1 = 5'd5;
        bus.address2 = 5'd6;
        commit(1, 5, 1, 1, 5, 2);
        chk("wrap_fwdData1_a", bus.fwdData1, 2);
        commit(1, 5, 3, 1, 6, 4);
        chk("wrap_count",    bus.count, 3);
        chk("wrap_fwdHit1",  bus.fwdHit1, 1);
        chk("wrap_fwdData1", bus.fwdData1, 3);
        chk("wrap_fwdHit2",  bus.fwdHit2, 1);
        chk("wrap_fwdData2", bus.fwdData2, 4);

        // Reset with a full FIFO: everything pending is discarded
        resetN = 1'b0;
        step();
        exp_q.delete();
        chk("midrst_count",    bus.count, 0);
        chk("midrst_regWrite", bus.regWrite, 0);
        chk("midrst_ready",    bus.commitReady, 1);
        chk("midrst_fwdHit1",  bus.fwdHit1, 0);
        resetN = 1'b1;
        step();
        chk("postrst_regWrite", bus.regWrite, 0);
        step();
        chk("postrst_regWrite_b", bus.regWrite, 0);

        // Normal operation resumes after reset
        commit(1, 7, 77, 0, 0, 0);
        chk("resume_wraddress", bus.wraddress, 7);
        chk("resume_wdata",     bus.wdata, 77);
        step();
        step();
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_commit_sequencer.md
Name: regfile_commit_sequencer

Overview:
- Sits between the ROB commit stage and register_file.
- Accepts up to two in-order commits per cycle into a small FIFO.
- Drains the FIFO one entry per cycle into the register file's single write port.
- Provides read-side forwarding of writes that are committed but not yet retired to the register file, so operand reads never see stale data.

Parameters:
- D_WIDTH, 31, MSB index of data (data is D_WIDTH+1 bits).
- A_WIDTH, 4, MSB index of register address (32 registers).
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk, input, 1, system clock.
- resetN, input, 1, synchronous active-low reset.
- commitValid0, input, 1, older commit slot valid.
- commitAddr0, input, A_WIDTH+1, destination register for slot 0.
- commitData0, input, D_WIDTH+1, result for slot 0.
- commitValid1, input, 1, younger commit slot valid.
- commitAddr1, input, A_WIDTH+1, destination register for slot 1.
- commitData1, input, D_WIDTH+1, result for slot 1.
- commitReady, output, 1, at least 2 free entries; ROB may commit this cycle.
- regWrite, output, 1, register file write enable.
- validCommit, output, 1, register file commit qualifier; equals regWrite.
- wraddress, output, A_WIDTH+1, register file write address.
- wdata, output, D_WIDTH+1, register file write data.
- address1, input, A_WIDTH+1, read port 1 address, mirrored from the register file read.
- address2, input, A_WIDTH+1, read port 2 address.
- fwdHit1, output, 1, pending write matches address1.
- fwdData1, output, D_WIDTH+1, youngest pending data for address1.
- fwdHit2, output, 1, pending write matches address2.
- fwdData2, output, D_WIDTH+1, youngest pending data for address2.
- count, output, clog2(DEPTH)+1, occupied entries.

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-low on resetN, sampled at the rising edge of clk.
- Reset values: head=0, tail=0, count=0. This gives regWrite=0, validCommit=0, commitReady=1, fwdHit1=0, fwdHit2=0. wraddress, wdata and fwdData are don't-care, but drive 0.
- Enqueue, at the rising edge while commitReady=1:
  - A slot is accepted if its commitValid is 1 and its commitAddr is not 0.
  - x0 writes are discarded, not stored.
  - Accepted entries are written in order, slot 0 then slot 1, at tail and tail+1 (mod DEPTH).
  - If only one slot is accepted, it takes tail.
  - Tail advances by the number accepted (0, 1 or 2).
- Commits while commitReady=0 are a protocol violation. They are ignored (no state change), and the bench asserts they never happen.
- Drain:
  - regWrite = (count != 0), combinational from registered state.
  - wraddress and wdata = head entry.
  - The register file always accepts, so every cycle with regWrite=1 pops the head at the rising edge.
  - A pushed entry reaches the write port the cycle after its enqueue edge at the earliest. Minimum latency: commit edge -> register file write edge = 1 cycle.
- Count: next = count + accepted − pop. Simultaneous push and pop is legal. Count never exceeds DEPTH.
- commitReady = (DEPTH − count) >= 2. Registered-state derived, with no combinational path from commit inputs.
- Forwarding, combinational:
  - For each read address, search all occupied entries, including the head being written this cycle.
  - The youngest match (nearest tail) wins.
  - Address 0 never hits.
  - Entries enqueued in the same cycle are not visible until the next cycle.
- Wrap-around: pointers are modulo DEPTH. Youngest-first ordering must remain correct across the wrap.
- Reset mid-operation: all pending entries are discarded, and no write is issued in the cycle after reset.

Decomposition:
- Package regfile_pkg:
  - D_WIDTH and A_WIDTH defaults.
  - Typedef reg_addr_t.
  - Typedef reg_data_t.
  - Struct commit_entry_t {reg_addr_t addr; reg_data_t data;}.
- One sub-module: pending_write_lookup. Combinational youngest-match search over the entry array given head and count, instantiated twice (once per read port).

Test Plan:
- Reset, then idle -> count=0, regWrite=0, commitReady=1, fwdHit1=0.
- Single commit (addr 4, data 60) -> next cycle regWrite=1, wraddress=4, wdata=60. The cycle after, count=0.
- Dual commit (addr 3, data 60) and (addr 3, data 9) in one cycle, address1=3 -> fwdHit1=1, fwdData1=9. Writes are issued as 60 then 9. After the drain, fwdHit1=0.
- Dual commits for 3 consecutive cycles with DEPTH=4 -> commitReady drops when count reaches 3. Check that no entry is lost and that write order matches commit order.
- Commit with addr 0 in slot 0 plus (addr 9, data 80) in slot 1 -> only addr 9 is written. address2=0 gives fwdHit2=0.
- Fill the FIFO, then drive resetN=0 for one edge -> count=0 and regWrite=0 in the following cycle. No write of stale data occurs.
